// File: rtl/button_event_decoder.sv
// Turns a debounced push-button level into short-press, long-press and double-click pulses.
// It also drives a held level for long holds and a wrapping count of every event emitted.
module button_event_decoder #(
   parameter int CNT_W        = 24,
   parameter int LONG_TICKS   = 5000000,
   parameter int DCLICK_TICKS = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pb_level,
   output logic       short_press,
   output logic       long_press,
   output logic       double_click,
   output logic       held,
   output logic [7:0] event_count
);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      WAIT_SECOND,
      SECOND_PRESSED,
      LONG_HELD
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             short_next;
   logic             long_next;
   logic             dclick_next;
   logic             event_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
         held         <= 1'b0;
         event_count  <= 8'h00;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         short_press  <= short_next;
         long_press   <= long_next;
         double_click <= dclick_next;
         // Held follows the next state so it rises together with the entry pulse.
         held         <= (state_next == LONG_HELD);
         if (event_fire) begin
            event_count <= event_count + 8'd1;
         end
      end
   end

   // A release or a new press always takes priority over a timeout on the same edge.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      short_next  = 1'b0;
      long_next   = 1'b0;
      dclick_next = 1'b0;
      case (state)
         IDLE: begin
            if (pb_level) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end
         end
         PRESSED: begin
            if (!pb_level) begin
               state_next = WAIT_SECOND;
               cnt_next   = '0;
            end else if (cnt == LONG_LAST) begin
               long_next  = 1'b1;
               state_next = LONG_HELD;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         WAIT_SECOND: begin
            if (pb_level) begin
               state_next = SECOND_PRESSED;
               cnt_next   = '0;
            end else if (cnt == DCLICK_LAST) begin
               short_next = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         SECOND_PRESSED: begin
            // A long second press still reports as a double click, never a long press.
            if (!pb_level) begin
               dclick_next = 1'b1;
               state_next  = IDLE;
            end else if (cnt == LONG_LAST) begin
               dclick_next = 1'b1;
               state_next  = LONG_HELD;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!pb_level) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign event_fire = short_next | long_next | dclick_next;

endmodule
